// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle RISC-V main controller: state sequencing and datapath control.
// Optional memory-wait handshake (mem_ready port) is built when MC_MEMWAIT_EN is defined.
module mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
`ifdef MC_MEMWAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pcwrite,
  output logic       irwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  state_t     st;
  logic       mem_ok;
  logic       legal_op;
  logic [1:0] aluop;

`ifdef MC_MEMWAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  assign state = st;

  always_comb begin
    legal_op = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= S_FETCH;
    end else begin
      case (st)
        S_FETCH:    if (run && mem_ok) st <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: st <= S_MEMADR;
            OP_RTYPE:          st <= S_EXECR;
            OP_ITYPE:          st <= S_EXECI;
            OP_BEQ:            st <= S_BEQ;
            OP_JAL:            st <= S_JAL;
            default:           st <= S_FETCH;
          endcase
        end
        S_MEMADR:   st <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ok) st <= S_MEMWB;
        S_MEMWB:    st <= S_FETCH;
        S_MEMWRITE: if (mem_ok) st <= S_FETCH;
        S_EXECR:    st <= S_ALUWB;
        S_EXECI:    st <= S_ALUWB;
        S_ALUWB:    st <= S_FETCH;
        S_BEQ:      st <= S_FETCH;
        S_JAL:      st <= S_ALUWB;
        default:    st <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the registered state; reset forces every output low at once.
  always_comb begin
    pcwrite   = 1'b0;
    irwrite   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluop     = ALUOP_ADD;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (st)
      S_FETCH: begin
        irwrite   = run & mem_ok;
        pcwrite   = run & mem_ok;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        illegal = ~legal_op;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD: adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        retire   = mem_ok;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_BEQ: begin
        alusrca = 2'b10;
        aluop   = ALUOP_SUB;
        pcwrite = zero;
        retire  = 1'b1;
      end
      S_JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase

    case (opcode)
      OP_STORE: immsrc = 2'b01;
      OP_BEQ:   immsrc = 2'b10;
      OP_JAL:   immsrc = 2'b11;
      default:  immsrc = 2'b00;
    endcase

    case (aluop)
      ALUOP_ADD: alucontrol = 3'b000;
      ALUOP_SUB: alucontrol = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alucontrol = (funct7b5 & opcode[5]) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
    endcase

    if (!rst_n) begin
      pcwrite    = 1'b0;
      irwrite    = 1'b0;
      adrsrc     = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      resultsrc  = 2'b00;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      immsrc     = 2'b00;
      alucontrol = 3'b000;
      retire     = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized self-checking bench for mc_controller against an instruction-level model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite, irwrite, adrsrc, memwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       retire, illegal;

  int vectors = 0;
  int miscompares = 0;

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero),
    .pcwrite(pcwrite), .irwrite(irwrite), .adrsrc(adrsrc), .memwrite(memwrite),
    .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .immsrc(immsrc), .alucontrol(alucontrol), .state(state), .retire(retire),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Instruction-level reference: state trajectory per opcode class, FETCH first.
  function automatic void model_path(input logic [6:0] op, output int path[$]);
    case (op)
      7'b0000011: path = '{0, 1, 2, 3, 4};
      7'b0100011: path = '{0, 1, 2, 5};
      7'b0110011: path = '{0, 1, 6, 8};
      7'b0010011: path = '{0, 1, 7, 8};
      7'b1100011: path = '{0, 1, 9};
      7'b1101111: path = '{0, 1, 10, 8};
      default:    path = '{0, 1};
    endcase
  endfunction

  function automatic logic [2:0] model_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    if (f3 == 3'd2) return 3'd5;
    if (f3 == 3'd6) return 3'd3;
    if (f3 == 3'd7) return 3'd2;
    if (f3 == 3'd0 && f7 && op == 7'b0110011) return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic [1:0] model_imm(input logic [6:0] op);
    if (op == 7'b0100011) return 2'd1;
    if (op == 7'b1100011) return 2'd2;
    if (op == 7'b1101111) return 2'd3;
    return 2'd0;
  endfunction

  // Entered just after a falling edge; leaves just after a falling edge with the DUT back in FETCH.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
    int path[$];
    int n_ret, n_ill, n_rw, n_mw, idle;
    bit is_legal, writes_reg;
    model_path(op, path);
    is_legal   = (path.size() > 2);
    writes_reg = (op == 7'b0000011) || (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b1101111);
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
    n_ret = 0; n_ill = 0; n_rw = 0; n_mw = 0;
    idle = $urandom_range(0, 2);
    run = 1'b0;
    repeat (idle) begin
      #1;
      check("idle_state", state, 0);
      check("idle_pcwrite", pcwrite, 0);
      check("idle_irwrite", irwrite, 0);
      @(negedge clk);
    end
    run = 1'b1;
    foreach (path[i]) begin
      #1;
      check("state", state, path[i]);
      check("immsrc", immsrc, model_imm(op));
      check("retire_illegal_excl", retire & illegal, 0);
      n_ret += retire; n_ill += illegal; n_rw += regwrite; n_mw += memwrite;
      if (path[i] == 0) begin
        check("fetch_irwrite", irwrite, 1);
        check("fetch_pcwrite", pcwrite, 1);
        check("fetch_alusrcb", alusrcb, 2);
        check("fetch_resultsrc", resultsrc, 2);
      end
      if (path[i] == 4) check("memwb_resultsrc", resultsrc, 1);
      if (path[i] == 6 || path[i] == 7) check("exec_alucontrol", alucontrol, model_alu(op, f3, f7));
      if (path[i] == 9) begin
        check("beq_pcwrite", pcwrite, z);
        check("beq_alucontrol", alucontrol, 1);
      end
      @(negedge clk);
      run = 1'b0;
    end
    #1;
    check("end_state", state, 0);
    check("retire_count", n_ret, is_legal ? 1 : 0);
    check("illegal_count", n_ill, is_legal ? 0 : 1);
    check("regwrite_count", n_rw, writes_reg ? 1 : 0);
    check("memwrite_count", n_mw, (op == 7'b0100011) ? 1 : 0);
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] op;
    rst_n = 1'b0; run = 1'b1; opcode = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_state", state, 0);
      check("rst_pcwrite", pcwrite, 0);
      check("rst_irwrite", irwrite, 0);
      check("rst_alusrcb", alusrcb, 0);
      check("rst_resultsrc", resultsrc, 0);
    end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      check("norun_state", state, 0);
      check("norun_pcwrite", pcwrite, 0);
      check("norun_irwrite", irwrite, 0);
    end
    @(negedge clk);

    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0);  // lw 0x00002083
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b0);  // add
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0);  // sub
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0);  // addi with bit 30 set
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1);  // beq taken
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b0);  // beq not taken
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0);  // illegal
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0);  // sw
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0);  // jal

    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 7))
        0: op = 7'b0000011;
        1: op = 7'b0100011;
        2: op = 7'b0110011;
        3: op = 7'b0010011;
        4: op = 7'b1100011;
        5: op = 7'b1101111;
        default: op = 7'($urandom);
      endcase
      run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom));
    end

    opcode = 7'b0100011; run = 1'b1;
    repeat (3) @(negedge clk);
    run = 1'b0;
    #1;
    check("midop_pre_state", state, 5);
    check("midop_pre_memwrite", memwrite, 1);
    rst_n = 1'b0;
    #1;
    check("midop_memwrite", memwrite, 0);
    check("midop_state", state, 0);
    check("midop_retire", retire, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_midop_state", state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle main controller for the RISC-V core. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback cycles. It drives every datapath enable and mux select, and reports instruction retirement and illegal-opcode events. It also holds the core idle in FETCH until the UART program loader asserts `run`.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `run` input 1: core enable; fetch starts only while high.
- `opcode` input 7: instruction bits [6:0], held valid by the instruction register from DECODE onward.
- `funct3` input 3: instruction bits [14:12].
- `funct7b5` input 1: instruction bit 30.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory ready; this port exists only with `MC_MEMWAIT_EN`.
- `pcwrite` output 1: PC register enable.
- `irwrite` output 1: instruction and old-PC register enable.
- `adrsrc` output 1: memory address select; 0 = PC, 1 = result.
- `memwrite` output 1: data memory write strobe.
- `regwrite` output 1: register file write enable.
- `resultsrc` output 2: result select; 00 = ALUOut, 01 = read data, 10 = live ALU result.
- `alusrca` output 2: ALU A select; 00 = PC, 01 = old PC, 10 = rd1.
- `alusrcb` output 2: ALU B select; 00 = rd2, 01 = immediate, 10 = constant 4.
- `immsrc` output 2: immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
- `alucontrol` output 3: ALU operation; 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `state` output 4: current state, for debug.
- `retire` output 1: one-cycle pulse when an instruction completes.
- `illegal` output 1: one-cycle pulse on an unsupported opcode.

## Operation
- **State encoding:** FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11–15 go to FETCH on the next edge with all enables 0.
- **Output style:** Moore outputs from registered state. Unlisted enables are 0 and unlisted selects are 00.
- **FETCH:**
  - Outputs: adrsrc=0, irwrite=1, pcwrite=1, alusrca=00, alusrcb=10, aluop=add, resultsrc=10.
  - Advances to DECODE only when `run`=1.
  - When `run`=0, irwrite and pcwrite are 0 and the state holds.
- **DECODE:**
  - Outputs: alusrca=01, alusrcb=01, aluop=add (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL.
  - Any other opcode → FETCH with `illegal`=1 for this cycle.
- **MEMADR:** alusrca=10, alusrcb=01, aluop=add. Goes to MEMREAD if opcode[5]=0, else MEMWRITE.
- **MEMREAD:** adrsrc=1, resultsrc=00. Next state MEMWB.
- **MEMWB:** resultsrc=01, regwrite=1, retire=1. Next state FETCH.
- **MEMWRITE:** adrsrc=1, resultsrc=00, memwrite=1, retire=1. Next state FETCH.
- **EXECR:** alusrca=10, alusrcb=00, aluop=funct. Next state ALUWB.
- **EXECI:** alusrca=10, alusrcb=01, aluop=funct. Next state ALUWB.
- **ALUWB:** resultsrc=00, regwrite=1, retire=1. Next state FETCH.
- **BEQ:**
  - Outputs: alusrca=10, alusrcb=00, aluop=sub, resultsrc=00, pcwrite=`zero`, retire=1.
  - Next state FETCH.
- **JAL:**
  - Outputs: alusrca=01, alusrcb=10, aluop=add, resultsrc=00, pcwrite=1.
  - Next state ALUWB; the link register is written there and retire is counted there.
- **immsrc:** decoded combinationally from opcode in every state.
  - 0100011 → 01; 1100011 → 10; 1101111 → 11; all others → 00.
- **ALU decode, funct mode:**
  - funct3 000 → sub when funct7b5 & opcode[5], else add.
  - funct3 010 → slt; 110 → or; 111 → and; any other funct3 → add.

## Timing
- **Cycles per instruction, FETCH inclusive, no waits:** lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4, illegal 2.
- **Reset:**
  - While `rst_n`=0, state=FETCH and every enable is forced to 0: pcwrite, irwrite, memwrite, regwrite, retire, illegal.
  - All selects and alucontrol are 0 during reset.
  - The first fetch is the first edge after release with `run`=1.
- **Reset mid-instruction:** an asserted `rst_n`=0 aborts immediately; no write strobe survives the assertion cycle.
- **`run` deassertion:** observed only in FETCH. An in-flight instruction always completes.
- **Pulse width:** `retire` and `illegal` are exactly one cycle per event and are never both high.

## Configuration
- **`MC_MEMWAIT_EN` defined:**
  - `mem_ready` port exists. FETCH, MEMREAD and MEMWRITE hold until `mem_ready`=1.
  - In FETCH, irwrite and pcwrite are gated by `mem_ready`.
  - In MEMWRITE, memwrite stays high while waiting; retire is asserted only in the cycle `mem_ready`=1.
- **Undefined:** no port; memory is assumed single-cycle and the cycle counts above hold exactly.

## Test plan
- **Reset/idle:** `rst_n`=0 for 3 cycles, then `run`=0 for 5 cycles → state=0, pcwrite=irwrite=0 throughout. Set `run`=1 → DECODE next cycle.
- **lw 0x00002083:** states 0,1,2,3,4,0 → regwrite=1 and resultsrc=01 only in MEMWB; retire exactly once.
- **add then sub:** R-type with funct3=000 and funct7b5=0 → alucontrol=000 in EXECR. The same with funct7b5=1 → 001. addi (0010011) with funct7b5=1 → 000.
- **beq:** `zero`=1 → pcwrite=1 in BEQ, 3-cycle instruction. `zero`=0 → pcwrite=0 in BEQ.
- **Illegal and wait:** opcode 1111111 → illegal=1 in DECODE, then FETCH, no regwrite/memwrite. With `MC_MEMWAIT_EN`, sw and `mem_ready` low for 3 cycles → memwrite held 4 cycles, retire in the 4th cycle only.
- **Reset mid-op:** `rst_n`=0 asserted during MEMWRITE → memwrite drops in the same cycle and state=0.
